// File: rtl/display_bcd_controller.sv
`timescale 1ns/1ps
// Seven-segment display controller: signed value -> iterative shift-add-3 BCD (one bit per clock),
// with raw-hex mode, overflow dashes and a one-deep pending write. Define DISPLAY_LZ_BLANK_EN to blank leading zeros.
module display_bcd_controller #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [WIDTH-1:0]    din,
  input  logic                hex_mode,
  output logic [7*DIGITS-1:0] seg,
  output logic [6:0]          sign_seg,
  output logic                dot,
  output logic                busy,
  output logic                ovf
);
  localparam int BW = 4*DIGITS + 4;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic                  neg_q, neg_d;
  logic                  hex_q, hex_d;
  logic                  hex_ovf_q, hex_ovf_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0]      pend_din_q, pend_din_d;
  logic                  pend_hex_q, pend_hex_d;
  logic [7*DIGITS-1:0]   seg_q, seg_d;
  logic [6:0]            sign_seg_q, sign_seg_d;
  logic                  ovf_q, ovf_d;

  logic                  start;
  logic [WIDTH-1:0]      src_din;
  logic signed [WIDTH-1:0] src_s;
  logic                  src_hex;
  logic                  src_hex_ovf;
  logic [BW-1:0]         bcd_adj;
  logic [4*DIGITS-1:0]   hex_pad;
  logic [7*DIGITS-1:0]   fmt_seg;
  logic                  fmt_ovf;

  function automatic logic [6:0] enc_digit(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS + 1; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Hex digits beyond the input width read as zero; bits beyond the display flag overflow.
  if (WIDTH >= 4*DIGITS) begin : g_hex_trunc
    assign hex_pad = mag_q[4*DIGITS-1:0];
  end else begin : g_hex_ext
    assign hex_pad = {{(4*DIGITS-WIDTH){1'b0}}, mag_q};
  end
  if (WIDTH > 4*DIGITS) begin : g_hex_ovf
    assign src_hex_ovf = |src_din[WIDTH-1:4*DIGITS];
  end else begin : g_hex_fit
    assign src_hex_ovf = 1'b0;
  end

  assign bcd_adj = add3(bcd_q);
  assign src_s   = src_din;

  always_comb begin
    logic [3:0] nib;
    logic [6:0] dig;
`ifdef DISPLAY_LZ_BLANK_EN
    logic seen;
    seen = 1'b0;
`endif
    fmt_seg = '1;
    fmt_ovf = hex_q ? hex_ovf_q : (ovf_acc_q | (|bcd_q[BW-1 -: 4]));
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = hex_q ? hex_pad[4*i +: 4] : bcd_q[4*i +: 4];
      if (fmt_ovf) begin
        dig = SEG_DASH;
      end else begin
        dig = enc_digit(nib);
`ifdef DISPLAY_LZ_BLANK_EN
        if (!hex_q && !seen && nib == 4'd0 && i != 0) dig = SEG_BLANK;
        if (nib != 4'd0) seen = 1'b1;
`endif
      end
      fmt_seg[7*i +: 7] = dig;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    ovf_acc_d  = ovf_acc_q;
    neg_d      = neg_q;
    hex_d      = hex_q;
    hex_ovf_d  = hex_ovf_q;
    pend_vld_d = pend_vld_q;
    pend_din_d = pend_din_q;
    pend_hex_d = pend_hex_q;
    seg_d      = seg_q;
    sign_seg_d = sign_seg_q;
    ovf_d      = ovf_q;
    start      = 1'b0;
    src_din    = din;
    src_hex    = hex_mode;

    case (state_q)
      IDLE: start = wr;
      CONV: begin
        // Bits pushed out of the guard nibble are remembered so huge values still flag overflow.
        bcd_d     = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
        ovf_acc_d = ovf_acc_q | bcd_adj[BW-1];
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        if (wr) begin
          pend_vld_d = 1'b1;
          pend_din_d = din;
          pend_hex_d = hex_mode;
        end
        if (cnt_q == CNT_LAST) state_d = COMMIT;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      COMMIT: begin
        seg_d      = fmt_seg;
        sign_seg_d = neg_q ? SEG_DASH : SEG_BLANK;
        ovf_d      = fmt_ovf;
        state_d    = IDLE;
        pend_vld_d = 1'b0;
        if (wr) begin
          start = 1'b1;
        end else if (pend_vld_q) begin
          start   = 1'b1;
          src_din = pend_din_q;
          src_hex = pend_hex_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      neg_d     = !src_hex && (src_s < 0);
      mag_d     = neg_d ? $unsigned(-src_s) : src_din;
      bcd_d     = '0;
      ovf_acc_d = 1'b0;
      hex_d     = src_hex;
      hex_ovf_d = src_hex_ovf;
      cnt_d     = '0;
      state_d   = src_hex ? COMMIT : CONV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= '1;
      sign_seg_q <= SEG_BLANK;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      sign_seg_q <= sign_seg_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mag_q      <= mag_d;
    bcd_q      <= bcd_d;
    ovf_acc_q  <= ovf_acc_d;
    neg_q      <= neg_d;
    hex_q      <= hex_d;
    hex_ovf_q  <= hex_ovf_d;
    pend_din_q <= pend_din_d;
    pend_hex_q <= pend_hex_d;
  end

  assign seg      = seg_q;
  assign sign_seg = sign_seg_q;
  assign ovf      = ovf_q;
  assign dot      = 1'b1;
  assign busy     = (state_q != IDLE);
endmodule
